// File: rtl/nand_tt_pkg.sv
// nand_tt_pkg: shared states, vector count and expected-response helper for the NAND truth-table checker
package nand_tt_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam int NUM_VEC = 4;

    function automatic logic exp_nand(input logic [1:0] vec);
        return ~(vec[1] & vec[0]);
    endfunction

endpackage

// File: rtl/nand_tt_checker_settle.sv
// tt_settle_timer: loadable down-counter that pulses expire on the last cycle of a vector's hold time
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int W = $clog2(SETTLE_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= W'(SETTLE_CYCLES);
        else if (run && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire = run && cnt == W'(1);

endmodule

// File: rtl/nand_tt_checker.sv
// nand_tt_checker: sweeps a 2-input gate through all vectors and scores its output against NAND
module nand_tt_checker
    import nand_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_PASSES      = 1,
    parameter int ERR_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               y,
    output logic               in1,
    output logic               in2,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [NUM_VEC-1:0] fail_vec
);

    localparam int PW = N_PASSES > 1 ? $clog2(N_PASSES) : 1;

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (N_PASSES < 1) begin : g_bad_passes
        $error("N_PASSES must be at least 1");
    end

    state_t             state, state_n;
    logic [1:0]         vec, vec_n;
    logic [PW-1:0]      pcnt, pcnt_n;
    logic [ERR_W-1:0]   err_n;
    logic [NUM_VEC-1:0] fail_n;
    logic               load, expire, mis;

    tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .run    (state == DRIVE),
        .expire (expire)
    );

    // Case equality so an X/Z response is scored as a mismatch in simulation
    assign mis = (y === exp_nand(vec)) ? 1'b0 : 1'b1;

    always_comb begin
        state_n = state;
        vec_n   = vec;
        pcnt_n  = pcnt;
        err_n   = err_cnt;
        fail_n  = fail_vec;
        load    = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                err_n   = '0;
                fail_n  = '0;
                vec_n   = 2'd0;
                pcnt_n  = '0;
                load    = 1'b1;
                state_n = DRIVE;
            end
            DRIVE: state_n = expire ? SAMPLE : DRIVE;
            SAMPLE: begin
                if (mis) begin
                    err_n       = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);
                    fail_n[vec] = 1'b1;
                end
                if (vec != 2'(NUM_VEC - 1)) begin
                    vec_n   = vec + 2'd1;
                    load    = 1'b1;
                    state_n = DRIVE;
                end else if (pcnt != PW'(N_PASSES - 1)) begin
                    pcnt_n  = pcnt + PW'(1);
                    vec_n   = 2'd0;
                    load    = 1'b1;
                    state_n = DRIVE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= 2'd0;
            pcnt     <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            state    <= state_n;
            vec      <= vec_n;
            pcnt     <= pcnt_n;
            err_cnt  <= err_n;
            fail_vec <= fail_n;
        end
    end

    assign {in1, in2} = vec;
    assign busy       = state == DRIVE || state == SAMPLE;
    assign done       = state == DONE;
    assign pass       = done && err_cnt == '0;

endmodule

// File: tb/tb_nand_tt_checker.sv
// tb_nand_tt_checker: random truth-table gates scored against a counting model through a scoreboard
module tb_nand_tt_checker;

    localparam int SC = 2;
    localparam int NP = 4;
    localparam int EW = 3;
    localparam int LAT = 4 * NP * (SC + 1);

    typedef struct {
        int         e0;
        int         err;
        logic [3:0] fv;
        logic       ps;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          y;
    logic          in1, in2, busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic [3:0]    fail_vec;
    logic [3:0]    tt = 4'b0111;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic done_q = 1'b0;

    nand_tt_checker #(.SETTLE_CYCLES(SC), .N_PASSES(NP), .ERR_W(EW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .y        (y),
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec)
    );

    // Gate under test is an arbitrary truth table indexed by {in1,in2}
    assign y = tt[{in1, in2}];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] t, input int e0);
        exp_t m;
        int   n = 0;
        m.e0 = e0;
        m.fv = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (t[k] != (k != 3)) begin
                n += NP;
                m.fv[k] = 1'b1;
            end
        end
        m.err = n > (2 ** EW - 1) ? 2 ** EW - 1 : n;
        m.ps  = n == 0;
        return m;
    endfunction

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", cyc - mon_e.e0, LAT);
                chk("err_cnt", int'(err_cnt), mon_e.err);
                chk("fail_vec", int'(fail_vec), int'(mon_e.fv));
                chk("pass", int'(pass), int'(mon_e.ps));
            end
        end
        chk("busy_done_overlap", int'(busy && done), 0);
        done_q = done;
    end

    task automatic launch(input logic [3:0] t);
        @(negedge clk);
        tt = t;
        start = 1'b1;
        sb.push_back(model(t, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        chk("e0_busy", int'(busy), 1);
        chk("e0_done", int'(done), 0);
        chk("e0_err_clear", int'(err_cnt), 0);
        chk("e0_fail_clear", int'(fail_vec), 0);
        chk("e0_vec", int'({in1, in2}), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        chk("done_hold", int'(done), 1);
        chk("busy_low", int'(busy), 0);
        chk("last_vec", int'({in1, in2}), 3);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in"}, int'({in1, in2}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_cnt), 0);
        chk({tag, "_fail"}, int'(fail_vec), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        // Good gate, with a start pulse mid-run that must be ignored
        launch(4'b0111);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        // AND gate saturates the counter, then restart from DONE with a good gate
        launch(4'b1000);
        wait_done();
        launch(4'b0111);
        wait_done();
        // Output stuck high
        launch(4'b1111);
        wait_done();
        // Reset while vector 2 is driven aborts the run
        launch(4'b1000);
        begin
            int n = 0;
            while ({in1, in2} != 2'b10 && n < LAT) begin
                @(negedge clk);
                n++;
            end
            chk("reach_vec2", int'({in1, in2}), 2);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        chk_reset_outputs("abort");
        repeat (LAT + 4) begin
            @(negedge clk);
            chk("abort_no_done", int'(done || busy), 0);
        end
        // Random gates
        repeat (20) begin
            launch(4'($urandom_range(0, 15)));
            wait_done();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
